// File: rtl/cnn_inference_sequencer_pkg.sv
// Shared types and default sizes for the CNN inference sequencer.
package cnn_inference_sequencer_pkg;

  localparam int F_IN_W1                = 28;
  localparam int F_IN_H1                = 28;
  localparam int FEATURE_MAP_RESOLUTION = 8;
  localparam int FEATURE_MAP_ADDRWIDE   = 10;
  localparam int NUM_CLASSES            = 10;
  localparam int SEQ_TIMEOUT_CYC        = 65535;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_PRED,
    ARGMAX,
    RESULT
  } seq_state_e;

endpackage

// File: rtl/cnn_inference_sequencer_argmax_seq.sv
// Sequential argmax: consumes one score per step and keeps the best one.
// The first candidate (index 0) always loads, so negative signed scores
// are handled; later candidates replace it only when strictly greater.
module argmax_seq
  import cnn_inference_sequencer_pkg::*;
#(
  parameter int DATA_W      = FEATURE_MAP_RESOLUTION,
  parameter int IDX_W       = 4,
  parameter int PRED_SIGNED = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] score_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [IDX_W-1:0]  best_idx_o,
  output logic [DATA_W-1:0] best_score_o
);

  logic [IDX_W-1:0]  r_best_idx;
  logic [DATA_W-1:0] r_best_score;
  logic              w_greater;

  // Strict comparison in the selected number format.
  always_comb begin
    w_greater = 1'b0;
    if (PRED_SIGNED != 0) begin
      w_greater = $signed(score_i) > $signed(r_best_score);
    end else begin
      w_greater = score_i > r_best_score;
    end
  end

  // Best-so-far register; clear wins over step.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_best_idx   <= '0;
      r_best_score <= '0;
    end else if (clear_i) begin
      r_best_idx   <= '0;
      r_best_score <= '0;
    end else if (step_i && ((idx_i == '0) || w_greater)) begin
      r_best_idx   <= idx_i;
      r_best_score <= score_i;
    end
  end

  assign best_idx_o   = r_best_idx;
  assign best_score_o = r_best_score;

endmodule

// File: rtl/cnn_inference_sequencer.sv
// Frame sequencer in front of the CNN: streams one frame in, waits for the
// prediction, reduces it to an argmax class and hands it to the host.
// A watchdog turns a missing prediction into a timeout result.
module cnn_inference_sequencer
  import cnn_inference_sequencer_pkg::*;
#(
  parameter int IMG_W       = F_IN_W1,
  parameter int IMG_H       = F_IN_H1,
  parameter int DATA_W      = FEATURE_MAP_RESOLUTION,
  parameter int ADDR_W      = FEATURE_MAP_ADDRWIDE,
  parameter int NUM_CLS     = NUM_CLASSES,
  parameter int PRED_SIGNED = 0,
  parameter int TIMEOUT_CYC = SEQ_TIMEOUT_CYC,
  localparam int IDX_W      = (NUM_CLS > 1) ? $clog2(NUM_CLS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  input  logic                      pix_valid_i,
  input  logic [DATA_W-1:0]         pix_data_i,
  output logic                      pix_ready_o,
  output logic                      cnn_input_valid_o,
  output logic [DATA_W-1:0]         cnn_input_data_o,
  output logic [ADDR_W-1:0]         cnn_input_addr_o,
  input  logic                      cnn_input_ready_i,
  input  logic                      cnn_pred_valid_i,
  input  logic [DATA_W*NUM_CLS-1:0] cnn_pred_data_i,
  output logic                      cnn_pred_ready_o,
  output logic                      result_valid_o,
  output logic [IDX_W-1:0]          result_class_o,
  output logic [DATA_W-1:0]         result_score_o,
  output logic                      result_timeout_o,
  input  logic                      result_ready_i,
  output logic [15:0]               frame_count_o
);

  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  seq_state_e                r_state;
  seq_state_e                w_next;
  logic [ADDR_W-1:0]         r_pix_cnt;
  logic [WD_W-1:0]           r_wd;
  logic [IDX_W-1:0]          r_idx;
  logic [DATA_W*NUM_CLS-1:0] r_pred;
  logic                      r_timeout;
  logic [15:0]               r_frame_cnt;
  logic                      w_capture;
  logic                      w_timeout_hit;
  logic                      w_frame_inc;
  logic [DATA_W-1:0]         w_score;
  logic [IDX_W-1:0]          w_best_idx;
  logic [DATA_W-1:0]         w_best_score;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and per-state port control; abort overrides everything.
  always_comb begin
    w_next            = r_state;
    busy_o            = (r_state != IDLE);
    result_valid_o    = (r_state == RESULT);
    pix_ready_o       = 1'b0;
    cnn_input_valid_o = 1'b0;
    cnn_input_data_o  = '0;
    cnn_input_addr_o  = '0;
    cnn_pred_ready_o  = 1'b0;
    w_capture         = 1'b0;
    w_timeout_hit     = 1'b0;
    w_frame_inc       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) w_next = LOAD;
      end
      LOAD: begin
        pix_ready_o       = cnn_input_ready_i;
        cnn_input_valid_o = pix_valid_i;
        cnn_input_data_o  = pix_data_i;
        cnn_input_addr_o  = r_pix_cnt;
        if (pix_valid_i && cnn_input_ready_i &&
            (r_pix_cnt == ADDR_W'(NUM_PIX - 1))) begin
          w_next = WAIT_PRED;
        end
      end
      WAIT_PRED: begin
        cnn_pred_ready_o = 1'b1;
        if (cnn_pred_valid_i) begin
          w_capture = 1'b1;
          w_next    = ARGMAX;
        end else if (r_wd == WD_W'(TIMEOUT_CYC - 1)) begin
          w_timeout_hit = 1'b1;
          w_next        = RESULT;
        end
      end
      ARGMAX: begin
        if (r_idx == IDX_W'(NUM_CLS - 1)) w_next = RESULT;
      end
      RESULT: begin
        if (result_ready_i) begin
          w_frame_inc = !r_timeout && !abort_i;
          w_next      = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    if (abort_i && (r_state != IDLE)) begin
      w_next        = IDLE;
      w_timeout_hit = 1'b0;
    end
  end

  // Pixel counter, watchdog, argmax index, captured scores and frame count.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pix_cnt   <= '0;
      r_wd        <= '0;
      r_idx       <= '0;
      r_pred      <= '0;
      r_timeout   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (r_state == LOAD) begin
        if (pix_valid_i && cnn_input_ready_i) r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
      end else begin
        r_pix_cnt <= '0;
      end
      r_wd  <= (r_state == WAIT_PRED) ? r_wd + WD_W'(1) : '0;
      r_idx <= (r_state == ARGMAX) ? r_idx + IDX_W'(1) : '0;
      if (w_capture) r_pred <= cnn_pred_data_i;
      if (r_state == IDLE) begin
        r_timeout <= 1'b0;
      end else if (w_timeout_hit) begin
        r_timeout <= 1'b1;
      end
      if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign w_score = r_pred[r_idx*DATA_W +: DATA_W];

  argmax_seq #(
    .DATA_W      (DATA_W),
    .IDX_W       (IDX_W),
    .PRED_SIGNED (PRED_SIGNED)
  ) u_argmax (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (r_state == WAIT_PRED),
    .step_i       (r_state == ARGMAX),
    .score_i      (w_score),
    .idx_i        (r_idx),
    .best_idx_o   (w_best_idx),
    .best_score_o (w_best_score)
  );

  assign result_class_o   = w_best_idx;
  assign result_score_o   = w_best_score;
  assign result_timeout_o = r_timeout;
  assign frame_count_o    = r_frame_cnt;

endmodule
